// File: rtl/hsm_cipher_core.sv
// Command-driven Feistel cipher engine with a 4-slot key store.
// HSM_CIPHER_IRQ_EN enables a registered done|err interrupt level.
module hsm_cipher_core #(
   parameter int NUM_ROUNDS = 8
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESETN,
   input  logic        cmd_valid,
   input  logic [3:0]  cmd_op,
   input  logic [1:0]  cmd_key_sel,
   input  logic [31:0] din,
   output logic        cmd_ready,
   output logic [31:0] dout,
   output logic [31:0] status,
   output logic        irq
);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ZERO} state_t;

   localparam logic [4:0] LP_NR = 5'(NUM_ROUNDS);

   state_t      r_state, w_state_nxt;
   logic [31:0] r_key [4];
   logic [31:0] w_key_nxt [4];
   logic [3:0]  r_kv, w_kv_nxt;
   logic [15:0] r_l, w_l_nxt;
   logic [15:0] r_r, w_r_nxt;
   logic [1:0]  r_sel, w_sel_nxt;
   logic        r_dec, w_dec_nxt;
   logic [4:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_dout, w_dout_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic        r_err, w_err_nxt;
   logic        r_ovr, w_ovr_nxt;
   logic [15:0] r_opcnt, w_opcnt_nxt;
   logic        r_irq, w_irq_nxt;

   logic [4:0]  w_ridx;
   logic [31:0] w_key;
   logic [15:0] w_rk;
   logic [15:0] w_x;
   logic [15:0] w_f;
   logic [15:0] w_l_rnd;
   logic [15:0] w_r_rnd;

   // Decryption walks the round indices backwards over the same counter
   assign w_ridx = r_dec ? (LP_NR - 5'd1 - r_cnt) : r_cnt;
   assign w_key  = r_key[r_sel];
   assign w_rk   = w_ridx[0] ? w_key[31:16] : w_key[15:0];
   assign w_x    = r_dec ? r_l : r_r;
   assign w_f    = {w_x[12:0], w_x[15:13]} + (w_rk ^ {11'd0, w_ridx});

   always_comb begin
      w_l_rnd = r_r;
      w_r_rnd = r_l ^ w_f;
      if (r_dec) begin
         w_l_rnd = r_r ^ w_f;
         w_r_rnd = r_l;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_kv_nxt    = r_kv;
      w_l_nxt     = r_l;
      w_r_nxt     = r_r;
      w_sel_nxt   = r_sel;
      w_dec_nxt   = r_dec;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      w_err_nxt   = r_err;
      w_ovr_nxt   = r_ovr;
      w_opcnt_nxt = r_opcnt;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_done_nxt = 1'b0;
               w_err_nxt  = 1'b0;
               w_ovr_nxt  = 1'b0;
               case (cmd_op)
                  4'd0: ;
                  4'd1: begin
                     w_key_nxt[cmd_key_sel] = din;
                     w_kv_nxt[cmd_key_sel]  = 1'b1;
                     w_done_nxt  = 1'b1;
                     w_opcnt_nxt = r_opcnt + 16'd1;
                  end
                  4'd2, 4'd3: begin
                     if (r_kv[cmd_key_sel]) begin
                        w_l_nxt     = din[31:16];
                        w_r_nxt     = din[15:0];
                        w_sel_nxt   = cmd_key_sel;
                        w_dec_nxt   = cmd_op[0];
                        w_cnt_nxt   = 5'd0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_ROUND;
                     end else begin
                        w_err_nxt = 1'b1;
                     end
                  end
                  4'd4: begin
                     w_cnt_nxt   = 5'd0;
                     w_busy_nxt  = 1'b1;
                     w_state_nxt = S_ZERO;
                  end
                  default: w_err_nxt = 1'b1;
               endcase
            end
         end
         S_ROUND: begin
            if (cmd_valid) w_ovr_nxt = 1'b1;
            if (r_cnt != LP_NR) begin
               w_l_nxt   = w_l_rnd;
               w_r_nxt   = w_r_rnd;
               w_cnt_nxt = r_cnt + 5'd1;
               if (r_cnt == LP_NR - 5'd1) w_busy_nxt = 1'b0;
            end else begin
               w_dout_nxt  = {r_l, r_r};
               w_done_nxt  = 1'b1;
               w_opcnt_nxt = r_opcnt + 16'd1;
               w_state_nxt = S_IDLE;
            end
         end
         S_ZERO: begin
            if (cmd_valid) w_ovr_nxt = 1'b1;
            if (r_cnt != 5'd4) begin
               w_key_nxt[r_cnt[1:0]] = 32'd0;
               w_kv_nxt[r_cnt[1:0]]  = 1'b0;
               w_cnt_nxt = r_cnt + 5'd1;
               if (r_cnt == 5'd3) w_busy_nxt = 1'b0;
            end else begin
               w_done_nxt  = 1'b1;
               w_opcnt_nxt = r_opcnt + 16'd1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
`ifdef HSM_CIPHER_IRQ_EN
      w_irq_nxt = w_done_nxt | w_err_nxt;
`else
      w_irq_nxt = 1'b0;
`endif
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= S_IDLE;
         for (int i = 0; i < 4; i++) r_key[i] <= 32'd0;
         r_kv    <= 4'd0;
         r_l     <= 16'd0;
         r_r     <= 16'd0;
         r_sel   <= 2'd0;
         r_dec   <= 1'b0;
         r_cnt   <= 5'd0;
         r_dout  <= 32'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_ovr   <= 1'b0;
         r_opcnt <= 16'd0;
         r_irq   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         for (int i = 0; i < 4; i++) r_key[i] <= w_key_nxt[i];
         r_kv    <= w_kv_nxt;
         r_l     <= w_l_nxt;
         r_r     <= w_r_nxt;
         r_sel   <= w_sel_nxt;
         r_dec   <= w_dec_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_ovr   <= w_ovr_nxt;
         r_opcnt <= w_opcnt_nxt;
         r_irq   <= w_irq_nxt;
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign dout      = r_dout;
   assign status    = {r_opcnt, 8'd0, r_kv, r_ovr, r_err, r_done, r_busy};
   assign irq       = r_irq;

endmodule

// File: tb/tb_hsm_cipher_core.sv
// Directed and randomized bench for hsm_cipher_core with an
// arithmetic reference model of the Feistel cipher.
module tb_hsm_cipher_core;

   localparam int NR = 8;
`ifdef HSM_CIPHER_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [3:0]  cmd_op = 4'd0;
   logic [1:0]  cmd_key_sel = 2'd0;
   logic [31:0] din = 32'd0;
   logic        cmd_ready;
   logic [31:0] dout;
   logic [31:0] status;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_key [4];
   logic [3:0]  m_kv;
   logic [15:0] m_cnt;
   logic [31:0] m_dout;

   hsm_cipher_core #(.NUM_ROUNDS(NR)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_op        (cmd_op),
      .cmd_key_sel   (cmd_key_sel),
      .din           (din),
      .cmd_ready     (cmd_ready),
      .dout          (dout),
      .status        (status),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rk(logic [31:0] k, int i);
      return (i % 2 == 0) ? k[15:0] : k[31:16];
   endfunction

   function automatic logic [15:0] ff(logic [15:0] x, logic [31:0] k, int i);
      logic [15:0] rot;
      rot = (x << 3) | (x >> 13);
      return rot + (rk(k, i) ^ 16'(i));
   endfunction

   function automatic logic [31:0] m_enc(logic [31:0] k, logic [31:0] x);
      logic [15:0] l, r, t;
      l = x[31:16];
      r = x[15:0];
      for (int i = 0; i < NR; i++) begin
         t = l ^ ff(r, k, i);
         l = r;
         r = t;
      end
      return {l, r};
   endfunction

   function automatic logic [31:0] m_dec(logic [31:0] k, logic [31:0] x);
      logic [15:0] l, r, t;
      l = x[31:16];
      r = x[15:0];
      for (int i = NR - 1; i >= 0; i--) begin
         t = r ^ ff(l, k, i);
         r = l;
         l = t;
      end
      return {l, r};
   endfunction

   function automatic logic [31:0] st(bit b, bit d, bit e, bit o);
      return {m_cnt, 8'd0, m_kv, o, e, d, b};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(string tag, bit b, bit d, bit e, bit o);
      chk({tag, ".status"}, status, st(b, d, e, o));
      chk({tag, ".irq"}, {31'd0, irq}, {31'd0, IRQ_EN & (d | e)});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(logic [3:0] op, logic [1:0] sel, logic [31:0] d);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_key_sel = sel;
      din         = d;
      cyc();
      cmd_valid   = 1'b0;
   endtask

   task automatic load(logic [1:0] sel, logic [31:0] k);
      issue(4'd1, sel, k);
      m_key[sel] = k;
      m_kv[sel]  = 1'b1;
      m_cnt++;
      chk_st("load", 0, 1, 0, 0);
   endtask

   task automatic wait_ready(string tag);
      int i = 0;
      while (cmd_ready !== 1'b1 && i < 50) begin
         cyc();
         i++;
      end
      chk({tag, ".timeout"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_key[i] = 32'd0;
      m_kv   = 4'd0;
      m_cnt  = 16'd0;
      m_dout = 32'd0;
   endtask

   initial begin
      logic [31:0] x, k, c;
      logic [1:0]  s;
      bit          d;
      model_reset();

      // reset values
      cyc();
      cyc();
      chk_st("rst", 0, 0, 0, 0);
      chk("rst.dout", dout, 32'd0);
      chk("rst.ready", {31'd0, cmd_ready}, 32'd1);
      rst_n = 1'b1;
      cyc();

      // reset asserted mid-round
      load(2'd0, $urandom);
      issue(4'd2, 2'd0, $urandom);
      cyc();
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_st("midrst", 0, 0, 0, 0);
      chk("midrst.dout", dout, 32'd0);
      chk("midrst.ready", {31'd0, cmd_ready}, 32'd1);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk_st("postrst", 0, 0, 0, 0);
      chk("postrst.ready", {31'd0, cmd_ready}, 32'd1);

      // load slot 2, then encrypt with cycle-level timing checks
      load(2'd2, 32'h01234567);
      issue(4'd2, 2'd2, 32'hDEADBEEF);
      for (int c2 = 0; c2 <= NR + 1; c2++) begin
         if (c2 == NR + 1) m_cnt++;
         chk_st("enc.t", c2 < NR, c2 == NR + 1, 0, 0);
         chk("enc.ready", {31'd0, cmd_ready}, {31'd0, c2 == NR + 1});
         if (c2 <= NR) cyc();
      end
      m_dout = m_enc(32'h01234567, 32'hDEADBEEF);
      chk("enc.dout", dout, m_dout);
      n_tests++;
      assert (dout !== 32'hDEADBEEF) else begin
         n_fail++;
         $error("FAIL enc.changed: observed %h expected not %h", dout, 32'hDEADBEEF);
      end

      c = dout;
      issue(4'd3, 2'd2, c);
      wait_ready("dec");
      m_cnt++;
      m_dout = 32'hDEADBEEF;
      chk("dec.dout", dout, m_dout);
      chk_st("dec", 0, 1, 0, 0);
      chk("dec.opcnt", {16'd0, status[31:16]}, 32'd3);

      // encrypt with no key loaded
      issue(4'd2, 2'd1, $urandom);
      chk_st("nokey", 0, 0, 1, 0);
      chk("nokey.dout", dout, m_dout);
      issue(4'd0, 2'd0, 32'd0);
      chk_st("nop", 0, 0, 0, 0);

      // command dropped while busy
      x = $urandom;
      issue(4'd2, 2'd2, x);
      cyc();
      issue(4'd1, 2'd1, $urandom);
      chk_st("ovr", 1, 0, 0, 1);
      wait_ready("ovr");
      m_cnt++;
      m_dout = m_enc(m_key[2], x);
      chk("ovr.dout", dout, m_dout);
      chk_st("ovr.end", 0, 1, 0, 1);

      // randomized encrypt/decrypt against the model
      for (int it = 0; it < 8; it++) begin
         s = 2'($urandom_range(0, 3));
         k = $urandom;
         x = $urandom;
         d = 1'($urandom_range(0, 1));
         load(s, k);
         issue(d ? 4'd3 : 4'd2, s, x);
         wait_ready("rnd");
         m_cnt++;
         m_dout = d ? m_dec(k, x) : m_enc(k, x);
         chk("rnd.dout", dout, m_dout);
         chk_st("rnd", 0, 1, 0, 0);
      end

      // zeroize with all slots loaded
      for (int i = 0; i < 4; i++) load(2'(i), $urandom);
      issue(4'd4, 2'd0, 32'd0);
      for (int c2 = 0; c2 <= 5; c2++) begin
         if (c2 >= 1 && c2 <= 4) m_kv[c2-1] = 1'b0;
         if (c2 == 5) m_cnt++;
         chk_st("zero.t", c2 < 4, c2 == 5, 0, 0);
         if (c2 < 5) cyc();
      end
      chk("zero.kv", {28'd0, status[7:4]}, 32'd0);

      // illegal opcode
      issue(4'd9, 2'd0, 32'd0);
      chk_st("illegal", 0, 0, 1, 0);

      // command accepted in the cycle the FSM returns to idle
      load(2'd3, 32'hCAFEF00D);
      x = $urandom;
      issue(4'd2, 2'd3, x);
      wait_ready("b2b");
      issue(4'd0, 2'd0, 32'd0);
      m_cnt++;
      m_dout = m_enc(32'hCAFEF00D, x);
      chk("b2b.dout", dout, m_dout);
      chk_st("b2b", 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
